// File: rtl/chirp_pkg.sv
// Shared types and constants for the LFM chirp phase generator.
package chirp_pkg;

    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_LEN_WIDTH   = 16;
    localparam int DEF_ROM_LATENCY = 2;

    // Quarter-period address offset (sine -> cosine) at the default LUT depth.
    localparam int QTR_OFFSET = 2 ** (DEF_ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } chirp_state_t;

    function automatic int qtr_offset(input int addr_width);
        return 2 ** (addr_width - 2);
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// DEPTH-stage shift register carrying {valid, last} alongside the ROM read pipeline.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    input  logic last_in,
    output logic valid_out,
    output logic last_out
);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] last_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr[0] <= valid_in;
            last_sr[0]  <= valid_in & last_in;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign valid_out = valid_sr[DEPTH-1];
    assign last_out  = last_sr[DEPTH-1];

endmodule

// File: rtl/chirp_phase_gen.sv
// Second-order phase accumulator driving a dual-port sine/cosine ROM, with aligned valid/last.
// Optional build macro CHIRP_PHASE_ROUND_EN rounds phase to the nearest address instead of truncating.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; zero-length start pulses done directly
//   ST_RUN   | one ROM read per cycle, phase/freq accumulate
//   ST_FLUSH | enables low, waiting ROM_LATENCY cycles for reads to emerge
module chirp_phase_gen
    import chirp_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int ROM_LATENCY = DEF_ROM_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PHASE_WIDTH-1:0] f0,
    input  logic [PHASE_WIDTH-1:0] k,
    input  logic [LEN_WIDTH-1:0]   n_samples,
    output logic                   rom_en_a,
    output logic                   rom_en_b,
    output logic [ADDR_WIDTH-1:0]  rom_addr_a,
    output logic [ADDR_WIDTH-1:0]  rom_addr_b,
    output logic                   iq_valid,
    output logic                   iq_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_WIDTH-1:0] QTR = ADDR_WIDTH'(qtr_offset(ADDR_WIDTH));
    localparam int FW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    function automatic logic [ADDR_WIDTH-1:0] phase_to_addr(input logic [PHASE_WIDTH-1:0] p);
`ifdef CHIRP_PHASE_ROUND_EN
        logic [PHASE_WIDTH-1:0] r;
        r = p + (PHASE_WIDTH'(1) << (PHASE_WIDTH - ADDR_WIDTH - 1));
        return r[PHASE_WIDTH-1 -: ADDR_WIDTH];
`else
        return p[PHASE_WIDTH-1 -: ADDR_WIDTH];
`endif
    endfunction

    chirp_state_t           state_q, state_nxt;
    logic [PHASE_WIDTH-1:0] phase_q, phase_nxt;
    logic [PHASE_WIDTH-1:0] freq_q, freq_nxt;
    logic [PHASE_WIDTH-1:0] k_q, k_nxt;
    logic [LEN_WIDTH-1:0]   remain_q, remain_nxt;
    logic [FW-1:0]          flush_q, flush_nxt;
    logic                   en_q, en_nxt;
    logic [ADDR_WIDTH-1:0]  addr_a_q, addr_a_nxt;
    logic [ADDR_WIDTH-1:0]  addr_b_q, addr_b_nxt;
    logic                   busy_q, busy_nxt;
    logic                   done_q, done_nxt;
    logic                   issue_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            freq_q   <= '0;
            k_q      <= '0;
            remain_q <= '0;
            flush_q  <= '0;
            en_q     <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            phase_q  <= phase_nxt;
            freq_q   <= freq_nxt;
            k_q      <= k_nxt;
            remain_q <= remain_nxt;
            flush_q  <= flush_nxt;
            en_q     <= en_nxt;
            addr_a_q <= addr_a_nxt;
            addr_b_q <= addr_b_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // phase_q/freq_q run one sample ahead of the registered address so outputs stay registered.
    always_comb begin
        state_nxt  = state_q;
        phase_nxt  = phase_q;
        freq_nxt   = freq_q;
        k_nxt      = k_q;
        remain_nxt = remain_q;
        flush_nxt  = flush_q;
        en_nxt     = 1'b0;
        addr_a_nxt = addr_a_q;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        issue_last = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (n_samples != '0) begin
                        state_nxt  = ST_RUN;
                        en_nxt     = 1'b1;
                        addr_a_nxt = phase_to_addr('0);
                        phase_nxt  = f0;
                        freq_nxt   = f0 + k;
                        k_nxt      = k;
                        remain_nxt = n_samples - LEN_WIDTH'(1);
                        busy_nxt   = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                issue_last = (remain_q == '0) || abort;
                if (issue_last) begin
                    state_nxt = ST_FLUSH;
                    flush_nxt = FW'(ROM_LATENCY - 1);
                end else begin
                    en_nxt     = 1'b1;
                    addr_a_nxt = phase_to_addr(phase_q);
                    phase_nxt  = phase_q + freq_q;
                    freq_nxt   = freq_q + k_q;
                    remain_nxt = remain_q - LEN_WIDTH'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_q == '0) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    flush_nxt = flush_q - FW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        addr_b_nxt = addr_a_nxt + QTR;
    end

    valid_delay_line #(
        .DEPTH (ROM_LATENCY)
    ) u_valid_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (en_q),
        .last_in   (issue_last),
        .valid_out (iq_valid),
        .last_out  (iq_last)
    );

    assign rom_en_a   = en_q;
    assign rom_en_b   = en_q;
    assign rom_addr_a = addr_a_q;
    assign rom_addr_b = addr_b_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_chirp_phase_gen.sv
// Self-checking bench for chirp_phase_gen: directed chirps plus randomized ones against a closed-form phase model.
module tb_chirp_phase_gen;

    localparam int AW = 10;
    localparam int PW = 32;
    localparam int LW = 16;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] f0 = '0;
    logic [PW-1:0] k = '0;
    logic [LW-1:0] n_samples = '0;
    logic          rom_en_a, rom_en_b;
    logic [AW-1:0] rom_addr_a, rom_addr_b;
    logic          iq_valid, iq_last, busy, done;

    int vectors = 0;
    int errors  = 0;
    logic [AW-1:0] obs_a[$];
    logic [AW-1:0] obs_b[$];

    chirp_phase_gen #(
        .ADDR_WIDTH (AW),
        .PHASE_WIDTH(PW),
        .LEN_WIDTH  (LW),
        .ROM_LATENCY(L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .f0        (f0),
        .k         (k),
        .n_samples (n_samples),
        .rom_en_a  (rom_en_a),
        .rom_en_b  (rom_en_b),
        .rom_addr_a(rom_addr_a),
        .rom_addr_b(rom_addr_b),
        .iq_valid  (iq_valid),
        .iq_last   (iq_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Sample i sits at phase sum_{j<i}(f0 + j*k) = i*f0 + k*i*(i-1)/2, mod 2^PW.
    function automatic logic [AW-1:0] model_addr(input logic [PW-1:0] mf0, input logic [PW-1:0] mk, input int i);
        logic [63:0] ii;
        logic [63:0] tri_n;
        logic [PW-1:0] p;
        ii    = 64'(i);
        tri_n = (i == 0) ? 64'd0 : (ii * (ii - 64'd1)) / 64'd2;
        p     = PW'(ii * 64'(mf0)) + PW'(tri_n * 64'(mk));
`ifdef CHIRP_PHASE_ROUND_EN
        p = p + (PW'(1) << (PW - AW - 1));
`endif
        return p[PW-1 -: AW];
    endfunction

    // Called at a negedge; returns at the negedge of the last checked cycle.
    task automatic run_chirp(input logic [PW-1:0] a_f0, input logic [PW-1:0] a_k, input int a_n,
                             input int abort_after, input int restart_at, input bit stray_abort,
                             input bit abort_with_start);
        int issued, done_cyc, last_c;
        bit exp_en, exp_valid, exp_last, exp_busy, exp_done;
        logic [AW-1:0] ea, eb;
        obs_a.delete();
        obs_b.delete();
        if (abort_with_start || a_n == 0) issued = 0;
        else if (abort_after > 0 && abort_after < a_n) issued = abort_after;
        else issued = a_n;
        if (abort_with_start) done_cyc = -1;
        else if (a_n == 0) done_cyc = 1;
        else done_cyc = issued + L + 1;
        last_c = (done_cyc > 0) ? done_cyc : L + 3;

        f0 = a_f0; k = a_k; n_samples = LW'(a_n);
        start = 1'b1; abort = abort_with_start;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= last_c; c++) begin
            exp_en    = (c <= issued);
            exp_valid = (issued > 0) && (c >= 1 + L) && (c <= issued + L);
            exp_last  = (issued > 0) && (c == issued + L);
            exp_busy  = (issued > 0) && (c <= issued + L);
            exp_done  = (c == done_cyc);
            vectors++;
            if ({rom_en_a, rom_en_b} !== {exp_en, exp_en}) begin
                errors++;
                $display("FAIL rom_en cyc %0d got %b%b exp %b", c, rom_en_a, rom_en_b, exp_en);
            end
            if (exp_en) begin
                ea = model_addr(a_f0, a_k, c - 1);
                eb = ea + AW'(256);
                obs_a.push_back(rom_addr_a);
                obs_b.push_back(rom_addr_b);
                vectors++;
                if (rom_addr_a !== ea) begin
                    errors++;
                    $display("FAIL addr_a cyc %0d got %0d exp %0d", c, rom_addr_a, ea);
                end
                vectors++;
                if (rom_addr_b !== eb) begin
                    errors++;
                    $display("FAIL addr_b cyc %0d got %0d exp %0d", c, rom_addr_b, eb);
                end
            end
            vectors++;
            if ({iq_valid, iq_last, busy, done} !== {exp_valid, exp_last, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL strobes cyc %0d got v%b l%b b%b d%b exp v%b l%b b%b d%b", c,
                         iq_valid, iq_last, busy, done, exp_valid, exp_last, exp_busy, exp_done);
            end
            start = (c == restart_at);
            if (start) begin
                f0 = $urandom; k = $urandom; n_samples = LW'($urandom_range(1, 9));
            end
            abort = (abort_after > 0 && c == abort_after) ||
                    (stray_abort && issued > 0 && c == issued + 1);
            if (c < last_c) @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({rom_en_a, rom_en_b, rom_addr_a, rom_addr_b, iq_valid, iq_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b %b %0d %0d %b %b %b %b exp all zero", rom_en_a, rom_en_b,
                     rom_addr_a, rom_addr_b, iq_valid, iq_last, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tone;
        run_chirp(32'h0040_0000, 32'h0, 8, 0, 3, 1'b0, 1'b0);
        vectors++;
        if (obs_a.size() != 8) begin
            errors++;
            $display("FAIL tone_count got %0d exp 8", obs_a.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (obs_a[i] !== AW'(i) || obs_b[i] !== AW'(256 + i)) begin
                    errors++;
                    $display("FAIL tone_addr idx %0d got %0d/%0d exp %0d/%0d", i, obs_a[i], obs_b[i], i, 256 + i);
                end
            end
        end
    endtask

    task automatic test_chirp;
        logic [AW-1:0] exp_a[5];
        exp_a = '{10'd0, 10'd0, 10'd1, 10'd3, 10'd6};
        run_chirp(32'h0, 32'h0040_0000, 5, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (i >= obs_a.size() || obs_a[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL chirp_addr idx %0d got %0d exp %0d", i, (i < obs_a.size()) ? obs_a[i] : 10'd0, exp_a[i]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_a[4];
        logic [AW-1:0] exp_b[4];
        exp_a = '{10'd0, 10'd512, 10'd0, 10'd512};
        exp_b = '{10'd256, 10'd768, 10'd256, 10'd768};
        run_chirp(32'h8000_0000, 32'h0, 4, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= obs_a.size() || obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL wrap_addr idx %0d got %0d/%0d exp %0d/%0d", i,
                         (i < obs_a.size()) ? obs_a[i] : 10'd0, (i < obs_b.size()) ? obs_b[i] : 10'd0,
                         exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_rounding;
        logic [AW-1:0] exp_a[5];
`ifdef CHIRP_PHASE_ROUND_EN
        exp_a = '{10'd0, 10'd1, 10'd1, 10'd2, 10'd2};
`else
        exp_a = '{10'd0, 10'd0, 10'd1, 10'd1, 10'd2};
`endif
        run_chirp(32'h0020_0000, 32'h0, 5, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (i >= obs_a.size() || obs_a[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL round_addr idx %0d got %0d exp %0d", i, (i < obs_a.size()) ? obs_a[i] : 10'd0, exp_a[i]);
            end
        end
    endtask

    task automatic test_handshake;
        run_chirp(32'h0040_0000, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        run_chirp(32'h0040_0000, 32'h0, 10, 2, 0, 1'b0, 1'b0);
        vectors++;
        if (obs_a.size() != 2) begin
            errors++;
            $display("FAIL abort_reads got %0d exp 2", obs_a.size());
        end
        run_chirp(32'h0040_0000, 32'h0, 6, 0, 0, 1'b0, 1'b1);
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_run;
        f0 = 32'h0040_0000; k = 32'h0; n_samples = LW'(10);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rom_en_a, rom_en_b, rom_addr_a, rom_addr_b, iq_valid, iq_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got en%b%b a%0d b%0d v%b l%b b%b d%b exp all zero", rom_en_a, rom_en_b,
                     rom_addr_a, rom_addr_b, iq_valid, iq_last, busy, done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if ({rom_en_a, iq_valid, iq_last, busy, done} !== 5'b0) begin
                errors++;
                $display("FAIL post_reset_quiet cyc %0d got en%b v%b l%b b%b d%b exp all zero", i,
                         rom_en_a, iq_valid, iq_last, busy, done);
            end
        end
        run_chirp(32'h0100_0000, 32'h0008_0000, 7, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [PW-1:0] rf0, rk;
        int rn, ra;
        for (int r = 0; r < 25; r++) begin
            rf0 = $urandom;
            rk  = $urandom;
            rn  = $urandom_range(1, 24);
            ra  = ($urandom_range(0, 3) == 0 && rn > 1) ? $urandom_range(1, rn - 1) : 0;
            run_chirp(rf0, rk, rn, ra, ($urandom_range(0, 1) == 1) ? 2 : 0,
                      (ra == 0) && ($urandom_range(0, 1) == 1), 1'b0);
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_chirp();
        test_wrap();
        test_rounding();
        test_handshake();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
